// File: rtl/cpu_mem_responder_pkg.sv
// Shared CPU definitions: loader FSM state encoding, NOP instruction,
// the idle value for the data read port, and the byte-to-word packing helper.
package cpu_mem_responder_pkg;

    // Loader / CPU-hold FSM states.
    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_LOAD_LO = 3'd1,
        ST_LOAD_HI = 3'd2,
        ST_DONE    = 3'd3,
        ST_RUN     = 3'd4
    } ld_state_t;

    // Instruction presented to the CPU whenever it is not running.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // Load data presented to the CPU whenever it is not running.
    localparam logic [7:0] IDLE_DATA = 8'h00;

    // Width of the instruction word address counter.
    localparam int PROG_ADDR_W = 8;

    // Program bytes arrive low byte first; the second byte is the high half.
    function automatic logic [15:0] pack_word(input logic [7:0] hi_byte,
                                              input logic [7:0] lo_byte);
        return {hi_byte, lo_byte};
    endfunction

endpackage

// File: rtl/cpu_mem_responder_prog_loader.sv
// prog_loader: turns a low-byte-first byte stream into 16-bit instruction
// memory writes and holds the CPU in reset until the program is in place.
module prog_loader
    import cpu_mem_responder_pkg::*;
#(
    parameter int IMEM_DEPTH = 256
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_ld_start,
    input  logic                   i_ld_valid,
    input  logic [7:0]             i_ld_byte,
    input  logic                   i_ld_last,
    output logic                   o_ld_ready,
    output logic                   o_ld_done,
    output logic                   o_cpu_hold,
    output logic                   o_run,
    output logic                   o_wr_en,
    output logic [PROG_ADDR_W-1:0] o_wr_addr,
    output logic [15:0]            o_wr_word
);

    // A load is forced to finish at the last instruction word, so the
    // counter never wraps back over word 0 mid-load.
    localparam logic [PROG_ADDR_W-1:0] LAST_ADDR = PROG_ADDR_W'(IMEM_DEPTH - 1);

    ld_state_t              r_state;
    logic [PROG_ADDR_W-1:0] r_count;
    logic [7:0]             r_lo_byte;
    logic                   r_ld_ready;
    logic                   r_ld_done;
    logic                   r_cpu_hold;
    logic                   r_run;

    logic                   w_wr_en;
    logic [15:0]            w_wr_word;

    // Loader FSM: state, word counter, staged low byte and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_HOLD;
            r_count    <= {PROG_ADDR_W{1'b0}};
            r_lo_byte  <= 8'h00;
            r_ld_ready <= 1'b0;
            r_ld_done  <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_run      <= 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    r_ld_done <= 1'b0;
                    if (i_ld_start) begin
                        r_state    <= ST_LOAD_LO;
                        r_count    <= {PROG_ADDR_W{1'b0}};
                        r_ld_ready <= 1'b1;
                    end else begin
                        r_state    <= ST_HOLD;
                        r_ld_ready <= 1'b0;
                    end
                    r_cpu_hold <= 1'b1;
                    r_run      <= 1'b0;
                end
                ST_LOAD_LO: begin
                    // ld_last has no meaning on a low byte.
                    r_ld_done <= 1'b0;
                    if (i_ld_valid) begin
                        r_lo_byte <= i_ld_byte;
                        r_state   <= ST_LOAD_HI;
                    end else begin
                        r_state   <= ST_LOAD_LO;
                    end
                    r_ld_ready <= 1'b1;
                    r_cpu_hold <= 1'b1;
                    r_run      <= 1'b0;
                end
                ST_LOAD_HI: begin
                    if (i_ld_valid) begin
                        if (i_ld_last || (r_count == LAST_ADDR)) begin
                            r_state    <= ST_DONE;
                            r_ld_ready <= 1'b0;
                            r_ld_done  <= 1'b1;
                        end else begin
                            r_state    <= ST_LOAD_LO;
                            r_count    <= r_count + {{(PROG_ADDR_W-1){1'b0}}, 1'b1};
                            r_ld_ready <= 1'b1;
                            r_ld_done  <= 1'b0;
                        end
                    end else begin
                        r_state    <= ST_LOAD_HI;
                        r_ld_ready <= 1'b1;
                        r_ld_done  <= 1'b0;
                    end
                    r_cpu_hold <= 1'b1;
                    r_run      <= 1'b0;
                end
                ST_DONE: begin
                    // Release the CPU one cycle after the completion pulse.
                    r_state    <= ST_RUN;
                    r_ld_ready <= 1'b0;
                    r_ld_done  <= 1'b0;
                    r_cpu_hold <= 1'b0;
                    r_run      <= 1'b1;
                end
                ST_RUN: begin
                    r_ld_done <= 1'b0;
                    if (i_ld_start) begin
                        r_state    <= ST_LOAD_LO;
                        r_count    <= {PROG_ADDR_W{1'b0}};
                        r_ld_ready <= 1'b1;
                        r_cpu_hold <= 1'b1;
                        r_run      <= 1'b0;
                    end else begin
                        r_state    <= ST_RUN;
                        r_ld_ready <= 1'b0;
                        r_cpu_hold <= 1'b0;
                        r_run      <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encodings recover to the safe held state.
                    r_state    <= ST_HOLD;
                    r_count    <= {PROG_ADDR_W{1'b0}};
                    r_ld_ready <= 1'b0;
                    r_ld_done  <= 1'b0;
                    r_cpu_hold <= 1'b1;
                    r_run      <= 1'b0;
                end
            endcase
        end
    end

    // Word write strobe: fires on the high-byte handshake; a reset on the
    // same edge aborts the partial word instead of committing it.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_word = pack_word(i_ld_byte, r_lo_byte);
        if ((r_state == ST_LOAD_HI) && i_ld_valid && !i_reset) begin
            w_wr_en = 1'b1;
        end else begin
            w_wr_en = 1'b0;
        end
    end

    assign o_ld_ready = r_ld_ready;
    assign o_ld_done  = r_ld_done;
    assign o_cpu_hold = r_cpu_hold;
    assign o_run      = r_run;
    assign o_wr_en    = w_wr_en;
    assign o_wr_addr  = r_count;
    assign o_wr_word  = w_wr_word;

endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: instruction and data memories for a small CPU, with a
// byte-stream program loader that keeps the CPU held until loading finishes.
module cpu_mem_responder
    import cpu_mem_responder_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  PC,
    output logic [15:0] InstrF,
    input  logic [7:0]  DataAdrM,
    input  logic [7:0]  WriteData,
    input  logic        MemWriteM,
    output logic [7:0]  ReadDataM,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_done,
    output logic        cpu_hold
);

    // Memory arrays are deliberately left out of reset so a reset can abort
    // a load without losing the words already written.
    logic [15:0] r_imem [0:IMEM_DEPTH-1];
    logic [7:0]  r_dmem [0:DMEM_DEPTH-1];

    logic                   w_run;
    logic                   w_imem_we;
    logic [PROG_ADDR_W-1:0] w_imem_addr;
    logic [15:0]            w_imem_word;
    logic                   w_dmem_we;
    logic [15:0]            w_instr;
    logic [7:0]             w_rdata;

    prog_loader #(
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_prog_loader (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_ld_start (ld_start),
        .i_ld_valid (ld_valid),
        .i_ld_byte  (ld_byte),
        .i_ld_last  (ld_last),
        .o_ld_ready (ld_ready),
        .o_ld_done  (ld_done),
        .o_cpu_hold (cpu_hold),
        .o_run      (w_run),
        .o_wr_en    (w_imem_we),
        .o_wr_addr  (w_imem_addr),
        .o_wr_word  (w_imem_word)
    );

    // Instruction memory write port, driven only by the loader.
    always_ff @(posedge clk) begin
        if (w_imem_we) begin
            r_imem[w_imem_addr] <= w_imem_word;
        end else begin
            r_imem[w_imem_addr] <= r_imem[w_imem_addr];
        end
    end

    // CPU stores are honoured only while the CPU is running.
    always_comb begin
        w_dmem_we = 1'b0;
        if (w_run && MemWriteM && !reset) begin
            w_dmem_we = 1'b1;
        end else begin
            w_dmem_we = 1'b0;
        end
    end

    // Data memory write port; the read below sees the pre-edge contents.
    always_ff @(posedge clk) begin
        if (w_dmem_we) begin
            r_dmem[DataAdrM] <= WriteData;
        end else begin
            r_dmem[DataAdrM] <= r_dmem[DataAdrM];
        end
    end

    // Zero-latency read ports, blanked to NOP / zero unless running.
    always_comb begin
        w_instr = NOP_INSTR;
        w_rdata = IDLE_DATA;
        if (w_run) begin
            w_instr = r_imem[PC];
            w_rdata = r_dmem[DataAdrM];
        end else begin
            w_instr = NOP_INSTR;
            w_rdata = IDLE_DATA;
        end
    end

    assign InstrF    = w_instr;
    assign ReadDataM = w_rdata;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed scenarios plus a random
// phase, all compared each cycle against a transaction-level memory model.
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  PC;
    logic [15:0] InstrF;
    logic [7:0]  DataAdrM;
    logic [7:0]  WriteData;
    logic        MemWriteM;
    logic [7:0]  ReadDataM;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_done;
    logic        cpu_hold;

    int tests = 0;
    int fails = 0;

    cpu_mem_responder #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
        .clk       (clk),
        .reset     (reset),
        .PC        (PC),
        .InstrF    (InstrF),
        .DataAdrM  (DataAdrM),
        .WriteData (WriteData),
        .MemWriteM (MemWriteM),
        .ReadDataM (ReadDataM),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_byte   (ld_byte),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .ld_done   (ld_done),
        .cpu_hold  (cpu_hold)
    );

    always #5 clk = ~clk;

    // Reference model: memory contents plus what the loader is doing.
    logic [15:0] m_imem [256];
    bit          m_ik   [256];
    logic [7:0]  m_dmem [256];
    bit          m_dk   [256];
    bit          m_valid   = 1'b0;
    bit          m_loading = 1'b0;
    bit          m_have_lo = 1'b0;
    bit          m_done    = 1'b0;
    bit          m_running = 1'b0;
    int          m_widx    = 0;
    logic [7:0]  m_lo      = 8'h00;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare outputs for the current inputs, then advance the model by one edge.
    task automatic step();
        bit was_running;
        #1;
        if (m_valid) begin
            chk("ld_ready", {15'd0, ld_ready}, {15'd0, m_loading});
            chk("ld_done",  {15'd0, ld_done},  {15'd0, m_done});
            chk("cpu_hold", {15'd0, cpu_hold}, {15'd0, !m_running});
            if (!m_running) begin
                chk("instr_nop", InstrF, 16'h0000);
                chk("rdata_zero", {8'd0, ReadDataM}, 16'h0000);
            end else begin
                if (m_ik[PC])       chk("instr", InstrF, m_imem[PC]);
                if (m_dk[DataAdrM]) chk("rdata", {8'd0, ReadDataM}, {8'd0, m_dmem[DataAdrM]});
            end
        end
        @(posedge clk);
        was_running = m_running;
        if (reset) begin
            m_valid = 1'b1; m_loading = 1'b0; m_have_lo = 1'b0;
            m_done = 1'b0;  m_running = 1'b0; m_widx = 0;
        end else if (m_valid) begin
            if (was_running && MemWriteM) begin
                m_dmem[DataAdrM] = WriteData;
                m_dk[DataAdrM]   = 1'b1;
            end
            if (m_done) begin
                m_done = 1'b0; m_running = 1'b1;
            end else if (m_loading) begin
                if (ld_valid) begin
                    if (!m_have_lo) begin
                        m_lo = ld_byte; m_have_lo = 1'b1;
                    end else begin
                        m_imem[m_widx] = {ld_byte, m_lo};
                        m_ik[m_widx]   = 1'b1;
                        m_have_lo      = 1'b0;
                        if (ld_last || m_widx == 255) begin
                            m_loading = 1'b0; m_done = 1'b1;
                        end else begin
                            m_widx++;
                        end
                    end
                end
            end else if (ld_start) begin
                m_loading = 1'b1; m_have_lo = 1'b0; m_widx = 0; m_running = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; MemWriteM = 1'b0; reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        idle(); ld_valid = 1'b1; ld_byte = b; ld_last = last; step();
    endtask

    task automatic start_load();
        idle(); ld_start = 1'b1; step();
    endtask

    task automatic do_reset();
        idle(); reset = 1'b1; step();
    endtask

    initial begin
        logic [7:0] old10;
        for (int i = 0; i < 256; i++) begin
            m_ik[i] = 1'b0; m_dk[i] = 1'b0;
        end
        idle(); reset = 1'b1; PC = 8'h00; DataAdrM = 8'h00; WriteData = 8'h00; ld_byte = 8'h00;
        @(negedge clk);
        step();
        step();
        // Reset state
        idle(); #1;
        chk("rst_hold", {15'd0, cpu_hold}, 16'h0001);
        chk("rst_ready", {15'd0, ld_ready}, 16'h0000);
        chk("rst_instr", InstrF, 16'h0000);
        step();

        // Basic two-word load
        start_load();
        send(8'h34, 1'b0); send(8'h12, 1'b0); send(8'h78, 1'b0); send(8'h56, 1'b1);
        idle(); #1; chk("done_pulse", {15'd0, ld_done}, 16'h0001); chk("done_hold", {15'd0, cpu_hold}, 16'h0001);
        step();
        idle(); PC = 8'h01; #1; chk("pc1_word", InstrF, 16'h5678); chk("run_hold", {15'd0, cpu_hold}, 16'h0000);
        step();
        PC = 8'h00; #1; chk("pc0_word", InstrF, 16'h1234);
        step();

        // Stall between low and high bytes
        start_load();
        send(8'hCD, 1'b1);
        for (int i = 0; i < 3; i++) begin idle(); step(); end
        send(8'hAB, 1'b1);
        idle(); step();
        PC = 8'h00; #1; chk("stall_word", InstrF, 16'hABCD);
        step();

        // Full-depth load forced to finish at word 255
        start_load();
        for (int i = 0; i < 512; i++) send(8'($urandom_range(0, 255)), 1'b0);
        idle(); ld_valid = 1'b1; ld_byte = 8'hEE; #1;
        chk("byte513_ready", {15'd0, ld_ready}, 16'h0000);
        step();
        idle(); step();
        for (int i = 0; i < 40; i++) begin PC = 8'($urandom_range(0, 255)); idle(); step(); end
        PC = 8'hFF; idle(); step();

        // Fill data memory, then the store-old-value check
        for (int i = 0; i < 256; i++) begin
            idle(); MemWriteM = 1'b1; DataAdrM = 8'(i); WriteData = 8'($urandom_range(0, 255)); step();
        end
        old10 = m_dmem[10];
        idle(); MemWriteM = 1'b1; DataAdrM = 8'd10; WriteData = 8'hAA; #1;
        chk("store_old", {8'd0, ReadDataM}, {8'd0, old10});
        step();
        idle(); DataAdrM = 8'd10; #1; chk("store_new", {8'd0, ReadDataM}, 16'h00AA);
        step();

        // Store attempted while held, then reload from HOLD
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(); MemWriteM = 1'b1; DataAdrM = 8'd10; WriteData = 8'h55; step();
        end
        start_load();
        send(8'h11, 1'b0); send(8'h22, 1'b1);
        idle(); step(); idle(); step();
        DataAdrM = 8'd10; #1; chk("hold_store_drop", {8'd0, ReadDataM}, 16'h00AA);
        step();

        // Reset in the middle of a load, then reload from RUN
        begin
            logic [15:0] keep1;
            keep1 = m_imem[1];
            start_load();
            send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
            idle(); reset = 1'b1; ld_valid = 1'b1; ld_byte = 8'h04; step();
            idle(); #1; chk("abort_hold", {15'd0, cpu_hold}, 16'h0001); chk("abort_ready", {15'd0, ld_ready}, 16'h0000);
            step();
            start_load(); send(8'h99, 1'b0); send(8'h88, 1'b1); idle(); step(); idle(); step();
            start_load(); send(8'h77, 1'b0);
            for (int i = 0; i < 2; i++) begin idle(); step(); end
            send(8'h66, 1'b1); idle(); step();
            idle(); PC = 8'h00; #1; chk("reload_word", InstrF, 16'h6677);
            step();
            PC = 8'h01; #1; chk("abort_kept", InstrF, keep1);
            step();
        end

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            ld_start  = ($urandom_range(0, 19) == 0);
            ld_valid  = $urandom_range(0, 1) == 1;
            ld_last   = ($urandom_range(0, 3) == 0);
            ld_byte   = 8'($urandom_range(0, 255));
            MemWriteM = $urandom_range(0, 1) == 1;
            DataAdrM  = 8'($urandom_range(0, 255));
            WriteData = 8'($urandom_range(0, 255));
            PC        = 8'($urandom_range(0, 255));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
